// File: rtl/lcd_spectrum_renderer.sv
// Streams one RGB565 spectrum frame (address-window preamble, then raster pixels)
// as a valid/ready byte stream with a DC flag, keeping per-band decaying peak markers.
module lcd_spectrum_renderer #(
  parameter int          N_BANDS    = 8,
  parameter int          MAG_W      = 8,
  parameter int          LCD_WIDTH  = 240,
  parameter int          LCD_HEIGHT = 320,
  parameter int          BAR_W      = 30,
  parameter int          GAP        = 2,
  parameter int          PEAK_DECAY = 4,
  parameter logic [15:0] BG_COLOR   = 16'hFFFF,
  parameter logic [15:0] PEAK_COLOR = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_BANDS*MAG_W-1:0]   spectrum_data_flat,
  input  logic                       init_done,
  input  logic                       frame_req,
  output logic [7:0]                 out_byte,
  output logic                       out_dc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       frame_busy,
  output logic                       frame_done
);

  // Handshake: a byte moves when out_valid && out_ready; while stalled the
  // output register holds, and a new byte is loaded only when empty or accepted.
  localparam int CW = 16;

  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_CMD, S_PIX, S_LAST} state_t;

  state_t          state_q, state_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic            out_dc_q, out_dc_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      cmd_idx_q, cmd_idx_d;
  logic [CW-1:0]   x_q, x_d, r_q, r_d, col_q, col_d, band_q, band_d;
  logic            lo_q, lo_d;
  logic [CW-1:0]   h_q[N_BANDS], h_d[N_BANDS];
  logic [CW-1:0]   peak_q[N_BANDS], peak_d[N_BANDS];
  logic [3:0]      cnt_q[N_BANDS], cnt_d[N_BANDS];

  logic            ld;
  logic [15:0]     pix_color;
  logic [CW-1:0]   sel_h, sel_p;

  function automatic logic [CW-1:0] bar_height(input logic [MAG_W-1:0] m);
    logic [MAG_W+CW-1:0] p;
    p = {{CW{1'b0}}, m} * (MAG_W+CW)'(LCD_HEIGHT);
    return p[MAG_W +: CW];
  endfunction

  function automatic logic [15:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    return 16'hF800;
      3'd1:    return 16'hFC00;
      3'd2:    return 16'hFFE0;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'h07FF;
      3'd5:    return 16'h001F;
      3'd6:    return 16'h801F;
      default: return 16'hF81F;
    endcase
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [3:0] i);
    logic [15:0] wm1, hm1;
    wm1 = 16'(LCD_WIDTH - 1);
    hm1 = 16'(LCD_HEIGHT - 1);
    case (i)
      4'd0:    return 8'h2A;
      4'd3:    return wm1[15:8];
      4'd4:    return wm1[7:0];
      4'd5:    return 8'h2B;
      4'd8:    return hm1[15:8];
      4'd9:    return hm1[7:0];
      4'd10:   return 8'h2C;
      default: return 8'h00;
    endcase
  endfunction

  // Band counter saturates at N_BANDS, which also marks the columns past the last bar.
  always_comb begin
    sel_h = '0;
    sel_p = '0;
    for (int b = 0; b < N_BANDS; b++) begin
      if (band_q == CW'(b)) begin
        sel_h = h_q[b];
        sel_p = peak_q[b];
      end
    end
    pix_color = BG_COLOR;
    if (band_q < CW'(N_BANDS) && col_q < CW'(BAR_W - GAP)) begin
      if (r_q < sel_h)
        pix_color = palette(band_q[2:0]);
      else if (sel_p != '0 && r_q == sel_p - CW'(1))
        pix_color = PEAK_COLOR;
    end
  end

  assign ld = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    out_byte_d  = out_byte_q;
    out_dc_d    = out_dc_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cmd_idx_d   = cmd_idx_q;
    x_d         = x_q;
    r_d         = r_q;
    col_d       = col_q;
    band_d      = band_q;
    lo_d        = lo_q;
    for (int b = 0; b < N_BANDS; b++) begin
      h_d[b]    = h_q[b];
      peak_d[b] = peak_q[b];
      cnt_d[b]  = cnt_q[b];
    end
    case (state_q)
      S_IDLE: begin
        if (frame_req && init_done && !done_q) begin
          state_d = S_SNAP;
          busy_d  = 1'b1;
        end
      end
      S_SNAP: begin
        for (int b = 0; b < N_BANDS; b++) begin
          h_d[b] = bar_height(spectrum_data_flat[b*MAG_W +: MAG_W]);
          if (h_d[b] >= peak_q[b]) begin
            peak_d[b] = h_d[b];
            cnt_d[b]  = '0;
          end else if (cnt_q[b] == 4'(PEAK_DECAY - 1)) begin
            peak_d[b] = (peak_q[b] == '0) ? '0 : peak_q[b] - CW'(1);
            cnt_d[b]  = '0;
          end else begin
            cnt_d[b]  = cnt_q[b] + 4'd1;
          end
        end
        cmd_idx_d = '0;
        x_d       = '0;
        r_d       = CW'(LCD_HEIGHT - 1);
        col_d     = '0;
        band_d    = '0;
        lo_d      = 1'b0;
        state_d   = S_CMD;
      end
      S_CMD: begin
        if (ld) begin
          out_byte_d  = cmd_byte(cmd_idx_q);
          out_dc_d    = !(cmd_idx_q == 4'd0 || cmd_idx_q == 4'd5 || cmd_idx_q == 4'd10);
          out_valid_d = 1'b1;
          cmd_idx_d   = cmd_idx_q + 4'd1;
          if (cmd_idx_q == 4'd10) state_d = S_PIX;
        end
      end
      S_PIX: begin
        if (ld) begin
          out_byte_d  = lo_q ? pix_color[7:0] : pix_color[15:8];
          out_dc_d    = 1'b1;
          out_valid_d = 1'b1;
          lo_d        = !lo_q;
          if (lo_q) begin
            if (x_q == CW'(LCD_WIDTH - 1)) begin
              x_d    = '0;
              col_d  = '0;
              band_d = '0;
              r_d    = r_q - CW'(1);
              if (r_q == '0) state_d = S_LAST;
            end else begin
              x_d = x_q + CW'(1);
              if (col_q == CW'(BAR_W - 1)) begin
                col_d  = '0;
                band_d = (band_q < CW'(N_BANDS)) ? band_q + CW'(1) : band_q;
              end else begin
                col_d  = col_q + CW'(1);
              end
            end
          end
        end
      end
      S_LAST: begin
        // Final low byte is in the output register; finish once it is taken.
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_byte_q  <= '0;
      out_dc_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_idx_q   <= '0;
      x_q         <= '0;
      r_q         <= '0;
      col_q       <= '0;
      band_q      <= '0;
      lo_q        <= 1'b0;
      for (int b = 0; b < N_BANDS; b++) begin
        h_q[b]    <= '0;
        peak_q[b] <= '0;
        cnt_q[b]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_byte_q  <= out_byte_d;
      out_dc_q    <= out_dc_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_idx_q   <= cmd_idx_d;
      x_q         <= x_d;
      r_q         <= r_d;
      col_q       <= col_d;
      band_q      <= band_d;
      lo_q        <= lo_d;
      for (int b = 0; b < N_BANDS; b++) begin
        h_q[b]    <= h_d[b];
        peak_q[b] <= peak_d[b];
        cnt_q[b]  <= cnt_d[b];
      end
    end
  end

  assign out_byte   = out_byte_q;
  assign out_dc     = out_dc_q;
  assign out_valid  = out_valid_q;
  assign frame_busy = busy_q;
  assign frame_done = done_q;

endmodule
